// File: rtl/div_unit_if.sv
// Divider handshake bundle between the execute-stage ALU (master) and div_unit (slave).
// Shared width and op-code defines live here so every file sees them; each definition is guarded.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif
`ifndef ALU_DIV
`define ALU_DIV  4'd4
`endif
`ifndef ALU_DIVU
`define ALU_DIVU 4'd5
`endif
`ifndef ALU_REM
`define ALU_REM  4'd6
`endif
`ifndef ALU_REMU
`define ALU_REMU 4'd7
`endif

interface div_unit_if;
   logic                     div_start_i;
   logic [`ALU_OP_WIDTH-1:0] div_op_i;
   logic [`CPU_WIDTH-1:0]    dividend_i;
   logic [`CPU_WIDTH-1:0]    divisor_i;
   logic                     div_res_ready_o;
   logic [`CPU_WIDTH-1:0]    div_result_o;
   logic                     div_busy_o;

   modport master (
      output div_start_i, div_op_i, dividend_i, divisor_i,
      input  div_res_ready_o, div_result_o, div_busy_o
   );

   modport slave (
      input  div_start_i, div_op_i, dividend_i, divisor_i,
      output div_res_ready_o, div_result_o, div_busy_o
   );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Divide-by-zero and signed overflow bypass the iteration and finish in one cycle.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif
`ifndef ALU_DIV
`define ALU_DIV  4'd4
`endif
`ifndef ALU_DIVU
`define ALU_DIVU 4'd5
`endif
`ifndef ALU_REM
`define ALU_REM  4'd6
`endif
`ifndef ALU_REMU
`define ALU_REMU 4'd7
`endif

module div_unit (
   input  logic       clk,
   input  logic       rst_n,
   div_unit_if.slave  bus
);

   localparam int W = `CPU_WIDTH;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                   state_q, state_d;
   logic [W-1:0]             quot_q;
   logic [W-1:0]             rem_q;
   logic [W-1:0]             divisor_q;
   logic [W-1:0]             result_q;
   logic [4:0]               cnt_q;
   logic [`ALU_OP_WIDTH-1:0] op_q;
   logic                     sign_a_q, sign_b_q;
   logic                     ready_q, busy_q;

   // Accept-time decode of the live inputs
   logic         in_signed, in_rem, div_zero, overflow, special;
   logic [W-1:0] special_result, mag_a, mag_b;

   assign in_signed = (bus.div_op_i == `ALU_DIV) || (bus.div_op_i == `ALU_REM);
   assign in_rem    = (bus.div_op_i == `ALU_REM) || (bus.div_op_i == `ALU_REMU);
   assign div_zero  = (bus.divisor_i == '0);
   assign overflow  = in_signed && (bus.dividend_i == {1'b1, {(W-1){1'b0}}})
                      && (bus.divisor_i == '1);
   assign special   = div_zero || overflow;

   assign special_result = div_zero ? (in_rem ? bus.dividend_i : '1)
                                    : (in_rem ? '0 : {1'b1, {(W-1){1'b0}}});

   // 0x80000000 negates to itself, which reads correctly as unsigned 2^31
   assign mag_a = (in_signed && bus.dividend_i[W-1]) ? (~bus.dividend_i + 1'b1) : bus.dividend_i;
   assign mag_b = (in_signed && bus.divisor_i[W-1])  ? (~bus.divisor_i + 1'b1)  : bus.divisor_i;

   // One restoring step; the kept remainder is always below the divisor so it fits in W bits
   logic [W:0]   rem_shift;
   logic         rem_ge;
   logic [W-1:0] rem_sub, rem_step, quot_step;

   assign rem_shift = {rem_q, quot_q[W-1]};
   assign rem_ge    = (rem_shift >= {1'b0, divisor_q});
   assign rem_sub   = rem_shift[W-1:0] - divisor_q;
   assign rem_step  = rem_ge ? rem_sub : rem_shift[W-1:0];
   assign quot_step = {quot_q[W-2:0], rem_ge};

   logic         op_rem_q;
   logic [W-1:0] calc_result;

   assign op_rem_q = (op_q == `ALU_REM) || (op_q == `ALU_REMU);
   // Signs are only latched for signed ops, so unsigned results pass through untouched
   assign calc_result = op_rem_q ? (sign_a_q ? (~rem_step + 1'b1) : rem_step)
                                 : ((sign_a_q ^ sign_b_q) ? (~quot_step + 1'b1) : quot_step);

   always_comb begin
      // NOTE: default assigned first so no path through the case leaves state_d unassigned (no latch).
      state_d = state_q;
      unique case (state_q)
         IDLE: if (bus.div_start_i) state_d = special ? DONE : CALC;
         CALC: begin
            if (!bus.div_start_i)    state_d = IDLE;
            else if (cnt_q == 5'd31) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         quot_q    <= '0;
         rem_q     <= '0;
         divisor_q <= '0;
         result_q  <= '0;
         cnt_q     <= '0;
         op_q      <= '0;
         sign_a_q  <= 1'b0;
         sign_b_q  <= 1'b0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         // Flags follow the next state so they are registered, never combinational from inputs
         ready_q <= (state_d == DONE);
         busy_q  <= (state_d != IDLE);
         unique case (state_q)
            IDLE: if (bus.div_start_i) begin
               op_q      <= bus.div_op_i;
               sign_a_q  <= in_signed & bus.dividend_i[W-1];
               sign_b_q  <= in_signed & bus.divisor_i[W-1];
               quot_q    <= mag_a;
               divisor_q <= mag_b;
               rem_q     <= '0;
               cnt_q     <= '0;
               if (special) result_q <= special_result;
            end
            CALC: if (bus.div_start_i) begin
               rem_q  <= rem_step;
               quot_q <= quot_step;
               cnt_q  <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) result_q <= calc_result;
            end
            default: ;
         endcase
      end
   end

   assign bus.div_res_ready_o = ready_q;
   assign bus.div_busy_o      = busy_q;
   assign bus.div_result_o    = result_q;

endmodule
